lm70_spi_responder: RTL and testbench
=====================================

// Module: lm70_spi_responder
// PURPOSE
//  SPI responder (slave) emulating an LM70 temperature sensor; counterpart of the LM70 SPI
//  reader. Serialises a programmable temperature as a 16-bit LM70 frame on MISO while the
//  reader drives CS and SCK. Used as on-chip loopback target and bench sensor model.
//  Runs on clk, which must be >= 8x the SCK frequency. CS and SCK are oversampled.
// PARAMETERS
//  FRAME_BITS  16   bits per frame; bits beyond FRAME_BITS read as 0
//  MIN_BITS    8    SCK rising edges needed for a frame to count as complete
//  RESET_TEMP  25   signed 8-bit integer degC loaded into temp_cur at reset
//  RAMP_MIN    -8   ramp lower wrap bound, degC (RAMP feature only)
//  RAMP_MAX    99   ramp upper wrap bound, degC (RAMP feature only)
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  cs_n        in   1  SPI chip select from the reader, asynchronous
//  sck         in   1  SPI clock from the reader, asynchronous, idles low
//  miso        out  1  serial data to the reader (SIO)
//  miso_oe     out  1  1 while the frame is selected; pad enable for miso
//  temp_in     in   8  new temperature, signed integer degC
//  temp_valid  in   1  temp_in is valid
//  temp_ready  out  1  responder can accept temp_in
//  ramp_mode   in   1  1 = auto-ramp temperature (RAMP feature only)
//  frame_done  out  1  1-clk pulse when CS deasserts after a complete frame
//  frame_short out  1  1-clk pulse when CS deasserts with fewer than MIN_BITS rising edges
//  busy        out  1  1 while in SHIFT
// BEHAVIOUR
//  - Reset: clk is the clock. rst_n is asynchronous, active-low.
//  - Reset values: miso=0, miso_oe=0, frame_done=0, frame_short=0, busy=0, temp_ready=1.
//    State is IDLE. temp_cur=RESET_TEMP. pending=0.
//  - Sync: cs_n and sck each pass through a 2-flop synchroniser, then a prev flop.
//    cs_n flops reset to 1. sck flops reset to 0.
//    Edges are detected on the synchronised values.
//    Latency from a pin edge to its action is 3 clk.
//  - Frame: frame = {sext9(temp_cur), 2'b00, 3'b111, 2'b00}. This is the 11-bit two's
//    complement value at 0.25 C/LSB, then 111, then 00.
//    Example: 25 -> 16'h0C9C.
//  - FSM IDLE: miso_oe=0, miso=0.
//    On a cs fall: load shift_reg=frame, clear bit_cnt, go to SHIFT.
//    In the same cycle drive miso=frame[15] and miso_oe=1.
//  - FSM SHIFT, on an sck rise: bit_cnt++ (saturate at 31). The reader samples on this edge.
//  - FSM SHIFT, on an sck fall: shift_reg <<= 1 with 0 fill. miso=shift_reg[15] after the shift.
//    After FRAME_BITS shifts, miso stays 0.
//  - FSM SHIFT, on a cs rise: go to IDLE and drop miso_oe and miso on the same cycle.
//    If bit_cnt >= MIN_BITS, pulse frame_done; else pulse frame_short.
//  - A cs rise has priority over sck edges detected in the same cycle.
//  - Temperature handshake: temp_ready = ~pending.
//    When temp_valid & temp_ready, the value goes to temp_hold and pending=1.
//  - pending moves into temp_cur only in IDLE, on the first IDLE cycle. pending then clears.
//    temp_cur never changes mid-frame.
//  - A cs fall in the same cycle as a pending transfer loads the frame from temp_hold.
//    The frame uses the new value.
//  - Reset mid-frame: immediate return to the reset values. A partial frame produces no pulse.
// CONFIGURATION
//  LM70_RESP_RAMP_EN defined:
//  - When ramp_mode=1, temp_cur increments by 1 on every frame_done.
//  - After RAMP_MAX it wraps to RAMP_MIN.
//  - A pending external value wins over the increment in the same cycle.
//  LM70_RESP_RAMP_EN undefined:
//  - ramp_mode is ignored. No ramp logic is built.
//  - temp_cur changes only through the handshake.
// TESTING
//  - Reset with no update, then a 16-bit read -> reader captures 16'h0C9C, frame_done pulses once.
//  - temp_in=-1 with temp_valid, then a read -> 16'hFF9C. temp_ready is low for exactly 1 clk.
//  - temp_valid asserted mid-frame with temp_in=40 -> the current frame still carries 25.
//    The next frame carries 16'h141C.
//  - CS raised after 5 SCK rises -> frame_short=1, frame_done=0.
//    miso_oe=0 within 3 clk of the CS pin edge.
//  - 20-bit read -> bits 16..19 read 0. The next frame restarts at bit 15.
//  - RAMP_EN, ramp_mode=1, temp=98: three frames -> 98, 99, -8.
//    rst_n pulsed mid-frame -> miso=0, busy=0, temp_cur=25.

Source files
------------

// File: rtl/lm70_spi_responder.sv
// LM70 temperature-sensor SPI responder: serialises a programmable temperature frame on MISO.
// Optional auto-ramp of the temperature is built when LM70_RESP_RAMP_EN is defined.
module lm70_spi_responder #(
  parameter int FRAME_BITS = 16,
  parameter int MIN_BITS   = 8,
  parameter int RESET_TEMP = 25,
  parameter int RAMP_MIN   = -8,
  parameter int RAMP_MAX   = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       sck,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] temp_in,
  input  logic       temp_valid,
  output logic       temp_ready,
  input  logic       ramp_mode,
  output logic       frame_done,
  output logic       frame_short,
  output logic       busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int             FB    = FRAME_BITS;
  localparam int             PAD   = FRAME_BITS - 16;
  localparam logic [7:0]     RST_T = 8'(RESET_TEMP);
  localparam logic [4:0]     MIN_C = 5'(MIN_BITS);

  state_t          state;
  logic [1:0]      cs_s;
  logic [1:0]      sck_s;
  logic            cs_p;
  logic            sck_p;
  logic [FB-1:0]   shift_reg;
  logic [4:0]      bit_cnt;
  logic [7:0]      temp_cur;
  logic [7:0]      temp_hold;
  logic            pending;

  logic            cs_fall;
  logic            cs_rise;
  logic            sck_rise;
  logic            sck_fall;
  logic            take;
  logic [7:0]      temp_src;
  logic [15:0]     frame16;
  logic [FB-1:0]   frame_load;

  assign cs_fall  = cs_p & ~cs_s[1];
  assign cs_rise  = ~cs_p & cs_s[1];
  assign sck_rise = ~sck_p & sck_s[1];
  assign sck_fall = sck_p & ~sck_s[1];

  assign temp_ready = ~pending;
  assign take       = temp_valid & ~pending;

  // A value still pending at CS fall is the one that goes out in this frame.
  assign temp_src   = pending ? temp_hold : temp_cur;
  assign frame16    = {temp_src[7], temp_src, 2'b00, 3'b111, 2'b00};
  assign frame_load = FB'(frame16) << PAD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s  <= 2'b11;
      cs_p  <= 1'b1;
      sck_s <= 2'b00;
      sck_p <= 1'b0;
    end else begin
      cs_s  <= {cs_s[0], cs_n};
      cs_p  <= cs_s[1];
      sck_s <= {sck_s[0], sck};
      sck_p <= sck_s[1];
    end
  end

`ifdef LM70_RESP_RAMP_EN
  localparam logic [7:0] RMIN = 8'(RAMP_MIN);
  localparam logic [7:0] RMAX = 8'(RAMP_MAX);
  logic [7:0] temp_next;
  assign temp_next = (temp_cur == RMAX) ? RMIN : temp_cur + 8'd1;
`else
  logic unused_ramp;
  assign unused_ramp = ^{ramp_mode, 8'(RAMP_MIN), 8'(RAMP_MAX)};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_short <= 1'b0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      temp_cur    <= RST_T;
      temp_hold   <= RST_T;
      pending     <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_short <= 1'b0;
      if (take) begin
        temp_hold <= temp_in;
        pending   <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          busy    <= 1'b0;
          if (pending) begin
            temp_cur <= temp_hold;
            pending  <= 1'b0;
          end
          if (cs_fall) begin
            shift_reg <= frame_load;
            bit_cnt   <= '0;
            state     <= SHIFT;
            miso      <= frame_load[FB-1];
            miso_oe   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state   <= IDLE;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            busy    <= 1'b0;
            if (bit_cnt >= MIN_C) begin
              frame_done <= 1'b1;
`ifdef LM70_RESP_RAMP_EN
              if (ramp_mode && !pending)
                temp_cur <= temp_next;
`endif
            end else begin
              frame_short <= 1'b1;
            end
          end else if (sck_rise) begin
            if (bit_cnt != 5'd31)
              bit_cnt <= bit_cnt + 5'd1;
          end else if (sck_fall) begin
            shift_reg <= shift_reg << 1;
            miso      <= shift_reg[FB-2];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lm70_spi_responder.sv
// Scoreboard bench for lm70_spi_responder: a reader model drives CS/SCK,
// expected frames are queued at issue and checked when the DUT pulses.
module tb_lm70_spi_responder;

  typedef struct {
    logic        short_f;
    logic [31:0] word;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       sck = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] temp_in = 8'd0;
  logic       temp_valid = 1'b0;
  logic       temp_ready;
  logic       ramp_mode = 1'b0;
  logic       frame_done;
  logic       frame_short;
  logic       busy;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pulses = 0;
  int          n_issued = 0;
  logic [31:0] cap = '0;
  exp_t        sb[$];

  lm70_spi_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .sck        (sck),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .temp_in    (temp_in),
    .temp_valid (temp_valid),
    .temp_ready (temp_ready),
    .ramp_mode  (ramp_mode),
    .frame_done (frame_done),
    .frame_short(frame_short),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every end-of-frame pulse pops one expected frame.
  always @(negedge clk) begin
    if (rst_n && (frame_done || frame_short)) begin
      n_pulses++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: done=%b short=%b", frame_done, frame_short);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_done", {31'd0, frame_done}, {31'd0, ~e.short_f});
        check("pulse_short", {31'd0, frame_short}, {31'd0, e.short_f});
        check("frame_word", cap, e.word);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic spi_read(input int n, input logic [31:0] exp_word,
                          input logic exp_short);
    exp_t e;
    e.short_f = exp_short;
    e.word    = exp_word;
    sb.push_back(e);
    n_issued++;
    cap  = '0;
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    check("oe_on", {31'd0, miso_oe}, 32'd1);
    check("busy_on", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      cap = {cap[30:0], miso};
      sck = 1'b1;
      repeat (8) @(negedge clk);
      sck = 1'b0;
      repeat (8) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("oe_drop", {31'd0, miso_oe}, 32'd0);
    check("busy_drop", {31'd0, busy}, 32'd0);
    check("miso_idle", {31'd0, miso}, 32'd0);
    repeat (6) @(negedge clk);
  endtask

  task automatic set_temp(input logic [7:0] v);
    @(negedge clk);
    temp_in    = v;
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
    check("ready_low", {31'd0, temp_ready}, 32'd0);
    @(negedge clk);
    check("ready_back", {31'd0, temp_ready}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_short", {31'd0, frame_short}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, temp_ready}, 32'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    spi_read(16, 32'h0C9C, 1'b0);

    // Update arriving mid-frame must not disturb the frame in flight.
    fork
      spi_read(16, 32'h0C9C, 1'b0);
      begin
        repeat (40) @(negedge clk);
        temp_in    = 8'd40;
        temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
        check("ready_mid", {31'd0, temp_ready}, 32'd0);
      end
    join
    spi_read(16, 32'h141C, 1'b0);

    set_temp(8'hFF);
    spi_read(16, 32'hFF9C, 1'b0);

    spi_read(5, 32'h1F, 1'b1);
    spi_read(20, 32'hFF9C0, 1'b0);
    spi_read(16, 32'hFF9C, 1'b0);

    set_temp(8'd98);
    ramp_mode = 1'b1;
`ifdef LM70_RESP_RAMP_EN
    spi_read(16, 32'h311C, 1'b0);
    spi_read(16, 32'h319C, 1'b0);
    spi_read(16, 32'hFC1C, 1'b0);
`else
    spi_read(16, 32'h311C, 1'b0);
    spi_read(16, 32'h311C, 1'b0);
`endif

    // Reset in the middle of a frame: no pulse, back to reset temperature.
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sck = 1'b1;
      repeat (8) @(negedge clk);
      sck = 1'b0;
      repeat (8) @(negedge clk);
    end
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_miso", {31'd0, miso}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_read(16, 32'h0C9C, 1'b0);

    repeat (10) @(negedge clk);
    check("pulse_count", n_pulses, n_issued);
    check("queue_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
